// File: rtl/key_search_pkg.sv
// Shared types and key-slice helpers for the RC4 key-search controller.
package key_search_pkg;

  localparam int unsigned KEY_WIDTH = 24;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StRun,
    StStopAll,
    StReport
  } state_e;

  // Slices are equal-sized; (key_max + 1) is expected to divide evenly by n.
  function automatic logic [KEY_WIDTH-1:0] slice_start(input int unsigned i,
                                                       input int unsigned n,
                                                       input logic [KEY_WIDTH-1:0] key_max);
    int unsigned span;
    span = 32'(key_max) + 32'd1;
    return KEY_WIDTH'(i * (span / n));
  endfunction

  function automatic logic [KEY_WIDTH-1:0] slice_end(input int unsigned i,
                                                     input int unsigned n,
                                                     input logic [KEY_WIDTH-1:0] key_max);
    int unsigned span;
    span = 32'(key_max) + 32'd1;
    return KEY_WIDTH'((i + 1) * (span / n) - 1);
  endfunction

endpackage

// File: rtl/first_set_index.sv
// Priority encoder: reports whether any bit is set and the index of the lowest set bit.
module first_set_index #(
  parameter int unsigned Width = 4,
  parameter int unsigned IdxW  = (Width > 1) ? $clog2(Width) : 1
) (
  input  logic [Width-1:0] vec_i,
  output logic             valid_o,
  output logic [IdxW-1:0]  idx_o
);

  // Scan from the top down so the lowest set bit is the last to assign.
  always_comb begin
    idx_o = '0;
    for (int i = int'(Width) - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = IdxW'(i);
    end
  end

  assign valid_o = |vec_i;

endmodule

// File: rtl/key_search_controller.sv
// Launches NUM_CORES key-search cores on equal key slices, latches the first winner,
// stops the rest and reports the result until the next reset.
module key_search_controller
  import key_search_pkg::*;
#(
  parameter int unsigned           NUM_CORES = 4,
  parameter logic [KEY_WIDTH-1:0]  KEY_MAX   = 24'h3FFFFF,
  parameter int unsigned           CYC_W     = 32,
  localparam int unsigned          IDX_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  output logic                           key_found,
  output logic [KEY_WIDTH-1:0]           found_key,
  output logic [IDX_W-1:0]               found_core,
  output logic [CYC_W-1:0]               elapsed_cycles,
  output logic [NUM_CORES-1:0]           core_start,
  output logic [NUM_CORES-1:0]           core_stop,
  output logic [NUM_CORES-1:0]           core_done_ack,
  input  logic [NUM_CORES-1:0]           core_done,
  input  logic [NUM_CORES-1:0]           core_found_flag,
  input  logic [KEY_WIDTH*NUM_CORES-1:0] core_key,
  output logic [KEY_WIDTH*NUM_CORES-1:0] key_start_value,
  output logic [KEY_WIDTH*NUM_CORES-1:0] key_end_value
);

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_slice
    assign key_start_value[g*KEY_WIDTH +: KEY_WIDTH] = slice_start(g, NUM_CORES, KEY_MAX);
    assign key_end_value[g*KEY_WIDTH +: KEY_WIDTH]   = slice_end(g, NUM_CORES, KEY_MAX);
  end

  state_e               state_q, state_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 key_found_q, key_found_d;
  logic [KEY_WIDTH-1:0] found_key_q, found_key_d;
  logic [IDX_W-1:0]     found_core_q, found_core_d;
  logic [CYC_W-1:0]     elapsed_q, elapsed_d;
  logic [NUM_CORES-1:0] core_start_q, core_start_d;
  logic [NUM_CORES-1:0] core_stop_q, core_stop_d;
  logic [NUM_CORES-1:0] ack_q, ack_d;
  logic [NUM_CORES-1:0] seen_q, seen_d;

  logic [NUM_CORES-1:0] win_vec;
  logic [NUM_CORES-1:0] new_done;
  logic                 win_valid;
  logic [IDX_W-1:0]     win_idx;
  logic [KEY_WIDTH-1:0] win_key;
  logic [CYC_W-1:0]     elapsed_inc;

  assign win_vec     = core_done & core_found_flag;
  assign new_done    = core_done & ~seen_q;
  assign elapsed_inc = (&elapsed_q) ? elapsed_q : elapsed_q + CYC_W'(1);

  first_set_index #(
    .Width (NUM_CORES),
    .IdxW  (IDX_W)
  ) u_first_set_index (
    .vec_i   (win_vec),
    .valid_o (win_valid),
    .idx_o   (win_idx)
  );

  always_comb begin
    win_key = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (win_idx == IDX_W'(i)) win_key = core_key[i*KEY_WIDTH +: KEY_WIDTH];
    end
  end

  always_comb begin
    state_d      = state_q;
    key_found_d  = key_found_q;
    found_key_d  = found_key_q;
    found_core_d = found_core_q;
    elapsed_d    = elapsed_q;
    core_stop_d  = core_stop_q;
    seen_d       = seen_q;
    core_start_d = '0;
    ack_d        = '0;

    case (state_q)
      StIdle: begin
        if (start) state_d = StLaunch;
      end
      StLaunch: begin
        core_start_d = '1;
        elapsed_d    = '0;
        seen_d       = '0;
        state_d      = StRun;
      end
      StRun: begin
        elapsed_d = elapsed_inc;
        ack_d     = new_done;
        seen_d    = seen_q | new_done;
        // A win in the same cycle as exhaustion still reports the winner.
        if (win_valid) begin
          key_found_d  = 1'b1;
          found_key_d  = win_key;
          found_core_d = win_idx;
          core_stop_d  = '1;
          state_d      = StStopAll;
        end else if (&core_done) begin
          state_d = StReport;
        end
      end
      StStopAll: begin
        elapsed_d = elapsed_inc;
        ack_d     = new_done;
        seen_d    = seen_q | new_done;
        if (&core_done) state_d = StReport;
      end
      StReport: begin
        // Cores cannot be relaunched without a reset, so stay here.
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StLaunch) || (state_d == StRun) || (state_d == StStopAll);
    done_d = (state_d == StReport);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      key_found_q  <= 1'b0;
      found_key_q  <= '0;
      found_core_q <= '0;
      elapsed_q    <= '0;
      core_start_q <= '0;
      core_stop_q  <= '0;
      ack_q        <= '0;
      seen_q       <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      key_found_q  <= key_found_d;
      found_key_q  <= found_key_d;
      found_core_q <= found_core_d;
      elapsed_q    <= elapsed_d;
      core_start_q <= core_start_d;
      core_stop_q  <= core_stop_d;
      ack_q        <= ack_d;
      seen_q       <= seen_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign key_found      = key_found_q;
  assign found_key      = found_key_q;
  assign found_core     = found_core_q;
  assign elapsed_cycles = elapsed_q;
  assign core_start     = core_start_q;
  assign core_stop      = core_stop_q;
  assign core_done_ack  = ack_q;

endmodule

// File: tb/tb_key_search_controller.sv
// Scoreboard bench for key_search_controller: stimulus queues expected events, a negedge
// monitor pops and compares them as the DUT produces them.
module tb_key_search_controller;

  localparam int NC = 4;
  localparam logic [23:0] KMAX = 24'h3FFFFF;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, key_found;
  logic [23:0]   found_key;
  logic [1:0]    found_core;
  logic [31:0]   elapsed_cycles;
  logic [NC-1:0] core_start, core_stop, core_done_ack;
  logic [NC-1:0] core_done = '0;
  logic [NC-1:0] core_found_flag = '0;
  logic [24*NC-1:0] core_key = '0;
  logic [24*NC-1:0] key_start_value, key_end_value;

  key_search_controller #(
    .NUM_CORES (NC),
    .KEY_MAX   (KMAX),
    .CYC_W     (32)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .busy            (busy),
    .done            (done),
    .key_found       (key_found),
    .found_key       (found_key),
    .found_core      (found_core),
    .elapsed_cycles  (elapsed_cycles),
    .core_start      (core_start),
    .core_stop       (core_stop),
    .core_done_ack   (core_done_ack),
    .core_done       (core_done),
    .core_found_flag (core_found_flag),
    .core_key        (core_key),
    .key_start_value (key_start_value),
    .key_end_value   (key_end_value)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [NC-1:0] vec;
    int            at;
  } ack_t;

  typedef struct {
    logic [23:0] key;
    logic [1:0]  core;
    int          at;
  } win_t;

  typedef struct {
    bit          kf;
    logic [23:0] key;
    logic [1:0]  core;
    logic [3:0]  stop;
    int          elapsed;
    int          at;
  } res_t;

  int   start_q[$];
  ack_t ack_q[$];
  win_t win_q[$];
  res_t res_q[$];

  logic kf_prev = 1'b0;
  logic done_prev = 1'b0;

  always @(negedge clk) begin
    int   s;
    ack_t a;
    win_t w;
    res_t r;
    if (core_start != '0) begin
      if (start_q.size() == 0) chk("core_start_unexpected", 64'(core_start), 0);
      else begin
        s = start_q.pop_front();
        chk("core_start_vec", 64'(core_start), 64'hF);
        chk("core_start_cycle", 64'(cyc), 64'(s));
        chk("busy_at_launch", 64'(busy), 1);
      end
    end
    if (core_done_ack != '0) begin
      if (ack_q.size() == 0) chk("ack_unexpected", 64'(core_done_ack), 0);
      else begin
        a = ack_q.pop_front();
        chk("ack_vec", 64'(core_done_ack), 64'(a.vec));
        chk("ack_cycle", 64'(cyc), 64'(a.at));
      end
    end
    if (key_found && !kf_prev) begin
      if (win_q.size() == 0) chk("win_unexpected", 64'(key_found), 0);
      else begin
        w = win_q.pop_front();
        chk("win_key", 64'(found_key), 64'(w.key));
        chk("win_core", 64'(found_core), 64'(w.core));
        chk("win_stop", 64'(core_stop), 64'hF);
        chk("win_cycle", 64'(cyc), 64'(w.at));
      end
    end
    if (done && !done_prev) begin
      if (res_q.size() == 0) chk("done_unexpected", 64'(done), 0);
      else begin
        r = res_q.pop_front();
        chk("res_key_found", 64'(key_found), 64'(r.kf));
        chk("res_found_key", 64'(found_key), 64'(r.key));
        chk("res_found_core", 64'(found_core), 64'(r.core));
        chk("res_core_stop", 64'(core_stop), 64'(r.stop));
        chk("res_elapsed", 64'(elapsed_cycles), 64'(r.elapsed));
        chk("res_cycle", 64'(cyc), 64'(r.at));
        chk("res_busy", 64'(busy), 0);
      end
    end
    kf_prev   <= key_found;
    done_prev <= done;
  end

  // Per-run core schedule: done offset (cycles after RUN entry), found flag, key.
  int          d_arr[NC];
  bit          f_arr[NC];
  logic [23:0] k_arr[NC];

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_done"}, 64'(done), 0);
    chk({tag, "_key_found"}, 64'(key_found), 0);
    chk({tag, "_found_key"}, 64'(found_key), 0);
    chk({tag, "_found_core"}, 64'(found_core), 0);
    chk({tag, "_elapsed"}, 64'(elapsed_cycles), 0);
    chk({tag, "_core_start"}, 64'(core_start), 0);
    chk({tag, "_core_stop"}, 64'(core_stop), 0);
    chk({tag, "_ack"}, 64'(core_done_ack), 0);
  endtask

  task automatic do_reset(input bit check, input string tag);
    reset = 1'b1;
    start = 1'b0;
    core_done = '0;
    core_found_flag = '0;
    @(posedge clk);
    #1;
    if (check) check_zero(tag);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic run_search(input bit poke_start);
    int maxd, wi, e, r;
    logic [NC-1:0] vec;
    res_t res;
    maxd = 0;
    wi = -1;
    for (int i = 0; i < NC; i++) begin
      if (d_arr[i] > maxd) maxd = d_arr[i];
      if (f_arr[i] && (wi < 0 || d_arr[i] < d_arr[wi])) wi = i;
    end
    for (int i = 0; i < NC; i++) core_key[i*24 +: 24] = key_start_value[i*24 +: 24];

    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    e = cyc;
    start_q.push_back(e + 1);
    for (int t = 0; t <= maxd; t++) begin
      vec = '0;
      for (int i = 0; i < NC; i++) if (d_arr[i] == t) vec[i] = 1'b1;
      if (vec != '0) ack_q.push_back('{vec: vec, at: e + 2 + t});
    end
    r = e + 2 + maxd;
    if (wi >= 0) begin
      win_q.push_back('{key: k_arr[wi], core: 2'(wi), at: e + 2 + d_arr[wi]});
      if (e + 3 + d_arr[wi] > r) r = e + 3 + d_arr[wi];
      res = '{kf: 1'b1, key: k_arr[wi], core: 2'(wi), stop: 4'hF, elapsed: r - e - 1, at: r};
    end else begin
      res = '{kf: 1'b0, key: 24'h0, core: 2'd0, stop: 4'h0, elapsed: r - e - 1, at: r};
    end
    res_q.push_back(res);

    @(posedge clk);
    #1;
    for (int t = 0; t <= maxd; t++) begin
      for (int i = 0; i < NC; i++) begin
        if (d_arr[i] == t) begin
          core_done[i] = 1'b1;
          core_found_flag[i] = f_arr[i];
          core_key[i*24 +: 24] = k_arr[i];
        end
      end
      start = poke_start && (t == 1);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    for (int n = 0; n < 50 && res_q.size() != 0; n++) @(posedge clk);
    #1;
    chk("result_arrived", 64'(res_q.size()), 0);
  endtask

  initial begin
    logic [23:0] slice;
    slice = 24'((32'(KMAX) + 1) / NC);

    do_reset(1'b1, "reset");
    for (int i = 0; i < NC; i++) begin
      chk($sformatf("slice_start_%0d", i), 64'(key_start_value[i*24 +: 24]), 64'(i * slice));
      chk($sformatf("slice_end_%0d", i), 64'(key_end_value[i*24 +: 24]),
          64'((i + 1) * slice - 1));
    end

    // Core 2 wins, the others finish 5 cycles later; a stray start during RUN.
    d_arr = '{5, 5, 0, 5};
    f_arr = '{0, 0, 1, 0};
    k_arr = '{24'h000111, 24'h100222, 24'h2000A5, 24'h300333};
    run_search(1'b1);
    // Start in REPORT must not relaunch; result stays latched.
    start = 1'b1;
    repeat (4) @(posedge clk);
    #1 start = 1'b0;
    chk("report_done_sticky", 64'(done), 1);
    chk("report_key_frozen", 64'(found_key), 64'h2000A5);

    // Cores 1 and 3 find a key in the same cycle: lowest index wins.
    do_reset(1'b0, "");
    d_arr = '{4, 2, 6, 2};
    f_arr = '{1, 1, 0, 1};
    k_arr = '{24'h000444, 24'h100010, 24'h200555, 24'h300020};
    run_search(1'b0);

    // Exhaustion, staggered over 10 cycles.
    do_reset(1'b0, "");
    d_arr = '{1, 4, 7, 10};
    f_arr = '{0, 0, 0, 0};
    k_arr = '{24'h0FFFFF, 24'h1FFFFF, 24'h2FFFFF, 24'h3FFFFF};
    run_search(1'b0);

    // Reset in the middle of RUN.
    do_reset(1'b0, "");
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    start_q.push_back(cyc + 1);
    repeat (4) @(posedge clk);
    #1;
    chk("midrun_busy", 64'(busy), 1);
    do_reset(1'b1, "midrun_reset");

    // Randomised runs.
    for (int run = 0; run < 10; run++) begin
      do_reset(1'b0, "");
      for (int i = 0; i < NC; i++) begin
        d_arr[i] = int'($urandom_range(0, 12));
        f_arr[i] = ($urandom_range(0, 2) == 0);
        k_arr[i] = 24'(i * slice + $urandom_range(0, 32'(slice) - 1));
      end
      run_search(run[0]);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("start_q_drained", 64'(start_q.size()), 0);
    chk("ack_q_drained", 64'(ack_q.size()), 0);
    chk("win_q_drained", 64'(win_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
